// File: rtl/multu_if.sv
// Handshake and data bundle between a pipeline ALU stage and the
// sequential unsigned multiplier with its Hi/Lo result registers.
interface multu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             nop;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [1:0]       hilo_sel;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  // Pipeline side: issues multiply requests and Hi/Lo reads
  modport master (
    output start, nop, src_a, src_b, hilo_sel,
    input  busy, done, stall, hi, lo, rd_data
  );

  // Multiplier side
  modport slave (
    input  start, nop, src_a, src_b, hilo_sel,
    output busy, done, stall, hi, lo, rd_data
  );
endinterface

// File: rtl/multu_sequencer.sv
// Sequential shift-add unsigned multiplier (MIPS MULTU style).
// One iteration per clock; Hi/Lo are only written when a multiply
// completes, so reads during a multiply stall the pipeline.
module multu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  multu_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             accept;
  logic             last_iter;
  logic             read_req;
  logic [WIDTH:0]   sum;

  assign read_req  = (bus.hilo_sel == 2'b01) || (bus.hilo_sel == 2'b10);
  assign last_iter = (count == CW'(WIDTH - 1));

  // State register; reset aborts any multiply in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and pipeline-facing status outputs
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.stall  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.nop) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        bus.busy  = 1'b1;
        bus.stall = (bus.start && !bus.nop) || read_req;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        bus.stall  = (bus.start && !bus.nop) || read_req;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Partial sum: multiplicand added into the upper accumulator half
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (mplier[0]) begin
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
  end

  // Operand capture, shift-add iteration and Hi/Lo write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= bus.src_a;
            mplier <= bus.src_b;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= {1'b0, sum, acc[WIDTH-1:1]};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          count  <= count + 1'b1;
        end
        DONE: begin
          hi_reg <= acc[2*WIDTH-1:WIDTH];
          lo_reg <= acc[WIDTH-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  // Architectural read port straight from the current registers
  always_comb begin
    bus.rd_data = '0;
    if (bus.hilo_sel == 2'b01) begin
      bus.rd_data = hi_reg;
    end else if (bus.hilo_sel == 2'b10) begin
      bus.rd_data = lo_reg;
    end
  end

  assign bus.hi = hi_reg;
  assign bus.lo = lo_reg;

endmodule
